ip_accum: RTL and testbench

Pipelined, parametrised inner-product engine for the Axiline datapath. Each accepted beat carries LANES signed operand pairs; the block reduces them through a registered multiplier/adder-tree pipeline and accumulates a programmable number of beats (chunks) into one saturating dot product. An optional partial sum seeds the accumulation, and results leave through a valid/ready handshake with full backpressure. It replaces the single-cycle 4-lane combinational inner product wherever vectors are longer than one lane group.

---
 rtl/ip_accum.sv | 142 ++++++++++++++
 tb/tb_ip_accum.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ip_accum.sv
// ip_accum: pipelined saturating inner-product accumulator with valid/ready output.
// Four register stages: lane products, adder tree, accumulator, output.
module ip_accum #(
    parameter int BITWIDTH  = 8,
    parameter int LANES     = 4,
    parameter int ACC_WIDTH = 32,
    parameter int LEN_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [LEN_WIDTH-1:0]         cfg_len,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LANES*BITWIDTH-1:0]    x,
    input  logic [LANES*BITWIDTH-1:0]    w,
    input  logic [ACC_WIDTH-1:0]         psum,
    input  logic                         psum_sel,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ACC_WIDTH-1:0]         sum,
    output logic                         sat
);
    localparam int PW = 2 * BITWIDTH;
    // Tree never narrower than the exact lane sum, so the clamp always sees the true value.
    localparam int TW = (ACC_WIDTH > PW + $clog2(LANES) + 1) ? ACC_WIDTH : PW + $clog2(LANES) + 1;
    localparam int EW = TW + 1;
    localparam logic signed [EW-1:0] MAXV = {{(EW-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [EW-1:0] MINV = {{(EW-ACC_WIDTH+1){1'b1}}, {(ACC_WIDTH-1){1'b0}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    typedef enum logic {IDLE, ACCUM} state_t;
    state_t state, state_next;

    logic                        stall, accept, first, last;
    logic [LEN_WIDTH-1:0]        cnt, cnt_next, len_q, len_next, len_eff;
    logic                        v1, f1, l1, v2, f2, l2, v3, l3;
    logic signed [PW-1:0]        p1 [LANES];
    logic signed [ACC_WIDTH-1:0] s1, s2, acc, clamped;
    logic signed [TW-1:0]        tree, t2;
    logic signed [EW-1:0]        nxt;
    logic                        hi, lo, sat_acc, sat_next;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;
    assign accept   = in_valid & in_ready;

    always_comb begin
        first      = state == IDLE;
        len_eff    = first ? (cfg_len == '0 ? LEN_WIDTH'(1) : cfg_len) : len_q;
        last       = cnt == len_eff - LEN_WIDTH'(1);
        state_next = state;
        cnt_next   = cnt;
        len_next   = len_q;
        if (accept) begin
            state_next = last ? IDLE : ACCUM;
            cnt_next   = last ? '0 : cnt + LEN_WIDTH'(1);
            len_next   = len_eff;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            len_q <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            len_q <= len_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v1 <= 1'b0;
        end else if (~stall) begin
            v1 <= accept;
            f1 <= first;
            l1 <= last;
            s1 <= psum_sel ? psum : '0;
            for (int i = 0; i < LANES; i++)
                p1[i] <= PW'($signed(x[i*BITWIDTH +: BITWIDTH])) * PW'($signed(w[i*BITWIDTH +: BITWIDTH]));
        end
    end

    always_comb begin
        tree = '0;
        for (int i = 0; i < LANES; i++)
            tree = tree + TW'(p1[i]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v2 <= 1'b0;
        end else if (~stall) begin
            v2 <= v1;
            f2 <= f1;
            l2 <= l1;
            s2 <= s1;
            t2 <= tree;
        end
    end

    always_comb begin
        nxt      = EW'(f2 ? s2 : acc) + EW'(t2);
        hi       = nxt > MAXV;
        lo       = nxt < MINV;
        clamped  = hi ? ACC_MAX : lo ? ACC_MIN : nxt[ACC_WIDTH-1:0];
        sat_next = (~f2 & sat_acc) | hi | lo;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v3      <= 1'b0;
            l3      <= 1'b0;
            acc     <= '0;
            sat_acc <= 1'b0;
        end else if (~stall) begin
            v3 <= v2;
            l3 <= l2;
            if (v2) begin
                acc     <= clamped;
                sat_acc <= sat_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            sum       <= '0;
            sat       <= 1'b0;
        end else if (~stall) begin
            out_valid <= v3 & l3;
            if (v3 & l3) begin
                sum <= acc;
                sat <= sat_acc;
            end
        end
    end
endmodule

// File: tb/tb_ip_accum.sv
// tb_ip_accum: directed scoreboard bench for ip_accum at ACC_WIDTH 32 and 16 in lockstep.
module tb_ip_accum;
    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, in_ready16, psum_sel, out_valid, out_ready, sat;
    logic        out_valid16, sat16;
    logic [7:0]  cfg_len;
    logic [31:0] x, w, psum, sum, hold;
    logic [15:0] sum16;

    typedef struct {longint s32; bit t32; longint s16; bit t16;} exp_t;
    exp_t q[$];
    exp_t e;
    int n_chk = 0, n_fail = 0, mcnt = 0, mlen = 1;
    longint m32, m16;
    bit ms32, ms16;

    always #5 clk = ~clk;

    ip_accum u_dut (.clk(clk), .reset(reset), .cfg_len(cfg_len), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .w(w), .psum(psum), .psum_sel(psum_sel), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .sat(sat));

    ip_accum #(.ACC_WIDTH(16)) u_dut16 (.clk(clk), .reset(reset), .cfg_len(cfg_len), .in_valid(in_valid),
        .in_ready(in_ready16), .x(x), .w(w), .psum(psum[15:0]), .psum_sel(psum_sel), .out_valid(out_valid16),
        .out_ready(out_ready), .sum(sum16), .sat(sat16));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    function automatic logic [31:0] rep(input logic [7:0] b);
        return {4{b}};
    endfunction

    function automatic longint clampv(input longint v, input int wd, output bit s);
        longint mx;
        mx = (longint'(1) << (wd - 1)) - 1;
        s = (v > mx) || (v < -mx - 1);
        return (v > mx) ? mx : (v < -mx - 1) ? -mx - 1 : v;
    endfunction

    task automatic model(input logic [31:0] xp, input logic [31:0] wp, input int len, input bit sel, input int ps);
        longint d = 0;
        bit s;
        for (int i = 0; i < 4; i++)
            d += longint'($signed(xp[i*8 +: 8])) * longint'($signed(wp[i*8 +: 8]));
        if (mcnt == 0) begin
            mlen = (len == 0) ? 1 : len;
            m32 = sel ? longint'(ps) : 0;
            m16 = sel ? longint'($signed(ps[15:0])) : 0;
            ms32 = 0;
            ms16 = 0;
        end
        m32 = clampv(m32 + d, 32, s);
        ms32 |= s;
        m16 = clampv(m16 + d, 16, s);
        ms16 |= s;
        if (mcnt == mlen - 1) begin
            q.push_back('{m32, ms32, m16, ms16});
            mcnt = 0;
        end else mcnt++;
    endtask

    task automatic beat(input logic [31:0] xp, input logic [31:0] wp, input int len, input bit sel, input int ps);
        bit ok = 0;
        int n = 0;
        x = xp; w = wp; cfg_len = 8'(len); psum_sel = sel; psum = ps; in_valid = 1'b1;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (ok) model(xp, wp, len, sel, ps);
        else check("accept_timeout", 32'(ok), 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard: every handshake pops the oldest expected result for both widths.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (q.size() == 0) check("spurious_result", 32'(q.size()), 1);
            else begin
                e = q.pop_front();
                check("sum32", sum, 32'(e.s32));
                check("sat32", 32'(sat), 32'(e.t32));
                check("valid16", 32'(out_valid16), 1);
                check("sum16", 32'($signed(sum16)), 32'(e.s16));
                check("sat16", 32'(sat16), 32'(e.t16));
            end
        end
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; x = '0; w = '0; cfg_len = 8'd1; psum = '0; psum_sel = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("reset_in_ready", 32'(in_ready), 1);
        check("reset_in_ready16", 32'(in_ready16), 1);
        check("reset_out_valid", 32'(out_valid), 0);
        check("reset_sum", sum, 0);
        check("reset_sat", 32'(sat), 0);

        beat({8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5}, 1, 1'b1, 10);
        repeat (2) @(posedge clk);
        #1 check("latency_not_early", 32'(out_valid), 0);
        idle(1);
        check("latency_valid", 32'(out_valid), 1);
        check("seeded_sum", sum, 80);
        check("seeded_sat", 32'(sat), 0);
        idle(3);

        repeat (3) beat(rep(8'd127), rep(8'd127), 3, 1'b0, 0);
        beat(rep(8'd1), rep(8'd1), 1, 1'b0, 0);
        idle(2);
        check("b2b_first_valid", 32'(out_valid), 1);
        check("b2b_first_sum", sum, 193548);
        idle(1);
        check("b2b_second_valid", 32'(out_valid), 1);
        check("b2b_second_sum", sum, 4);
        idle(3);

        beat(rep(8'h80), rep(8'd127), 1, 1'b0, 999);
        idle(3);
        check("signed_sum", sum, -65024);
        beat({8'd4, 8'd3, 8'd2, 8'd1}, rep(8'd1), 2, 1'b1, 100);
        beat({8'd4, 8'd3, 8'd2, 8'd1}, rep(8'd1), 2, 1'b1, 5000);
        idle(3);
        check("psum_mid_vector", sum, 120);
        beat(rep(8'd2), rep(8'd3), 0, 1'b1, -7);
        idle(4);
        check("len_zero_sum", sum, 17);

        repeat (2) beat(rep(8'd127), rep(8'd127), 2, 1'b0, 0);
        beat(rep(8'd1), rep(8'd1), 1, 1'b0, 0);
        beat(rep(8'd127), rep(8'd127), 1, 1'b1, 2147483000);
        idle(4);
        check("sat32_boundary", sum, 32'h7fffffff);
        check("sat32_flag", 32'(sat), 1);
        idle(2);

        fork
            begin : stream
                for (int v = 0; v < 4; v++)
                    repeat (2) beat(rep(8'(v + 1)), rep(8'd2), 2, 1'b0, 0);
            end
            begin : stall_ctl
                int n;
                n = 0;
                while (!out_valid && n < 100) begin
                    @(posedge clk);
                    #1 n++;
                end
                check("bp_first_result", 32'(out_valid), 1);
                out_ready = 1'b0;
                hold = (q.size() > 0) ? 32'(q[0].s32) : 32'hdeadbeef;
                repeat (5) begin
                    idle(1);
                    check("bp_in_ready_low", 32'(in_ready), 0);
                    check("bp_valid_held", 32'(out_valid), 1);
                    check("bp_sum_stable", sum, hold);
                end
                out_ready = 1'b1;
            end
        join
        idle(10);

        beat(rep(8'd1), rep(8'd1), 4, 1'b0, 0);
        beat(rep(8'd1), rep(8'd1), 4, 1'b0, 0);
        reset = 1'b1;
        idle(1);
        check("midreset_out_valid", 32'(out_valid), 0);
        check("midreset_sum", sum, 0);
        check("midreset_sat", 32'(sat), 0);
        reset = 1'b0;
        mcnt = 0;
        beat({8'd4, 8'd3, 8'd2, 8'd1}, rep(8'd1), 1, 1'b0, 0);
        idle(3);
        check("post_reset_sum", sum, 10);
        idle(5);
        check("scoreboard_empty", 32'(q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
